// File: rtl/j4_slot_io_pkg.sv
// j4_slot_io_pkg
//   Shared definitions for the j4 per-slot IO peripheral: register
//   offsets within the 16-word IO window, slot count, the captured-access
//   record and a small decode helper.
package j4_slot_io_pkg;

  localparam int N_SLOT = 4;

  // Register offsets from BASE (mem_addr[3:0])
  localparam logic [3:0] OFF_SLOTID = 4'h0;
  localparam logic [3:0] OFF_KILL   = 4'h1;
  localparam logic [3:0] OFF_WDKICK = 4'h2;
  localparam logic [3:0] OFF_WDCNT  = 4'h3;
  localparam logic [3:0] OFF_MBSTAT = 4'h4;
  localparam logic [3:0] OFF_MBOX   = 4'h8;

  // A decoded write held for one cycle before it is applied
  typedef struct packed {
    logic        wr;
    logic [3:0]  off;
    logic [15:0] data;
    logic [1:0]  slot;
  } wr_acc_t;

  // Offsets 8..11 address the four mailboxes on writes
  function automatic logic is_mbox_off(input logic [3:0] o);
    return o[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/j4_slot_io_if.sv
// j4_slot_io_if
//   IO bus between the j4 barrel core (master) and the per-slot IO
//   peripheral (slave).
//   io_rd/io_wr  : access strobes
//   mem_addr     : IO address
//   dout         : write data
//   io_slot      : slot issuing the access
//   io_din       : registered read data back to the core
//   kill_slot_rq : one-cycle per-slot reboot request to the core
interface j4_slot_io_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [1:0]  io_slot;
  logic [15:0] io_din;
  logic [3:0]  kill_slot_rq;

  modport master (
    output io_rd, io_wr, mem_addr, dout, io_slot,
    input  io_din, kill_slot_rq
  );

  modport slave (
    input  io_rd, io_wr, mem_addr, dout, io_slot,
    output io_din, kill_slot_rq
  );
endinterface

// File: rtl/j4_slot_io_wdog.sv
// j4_wdog
//   One slot's watchdog down-counter. A nonzero count decrements on each
//   prescaler tick; reaching zero raises expire for that cycle and the
//   counter then stays at zero (disabled) until kicked again.
//   clk, resetq : clock, async active-low reset
//   tick        : one-cycle prescaler wrap pulse
//   kick        : load kick_val (0 disables)
//   clear       : force to zero (slot killed)
//   count       : remaining count
//   expire      : combinational 1->0 pulse, registered by the top
module j4_wdog (
  input  logic        clk,
  input  logic        resetq,
  input  logic        tick,
  input  logic        kick,
  input  logic [15:0] kick_val,
  input  logic        clear,
  output logic [15:0] count,
  output logic        expire
);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (kick) begin
      count <= kick_val;
    end else if (tick && count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  // A kick landing on the expiry tick reloads the counter instead of killing
  assign expire = tick && !kick && !clear && (count == 16'd1);

endmodule

// File: rtl/j4_slot_io.sv
// j4_slot_io
//   Per-slot IO peripheral for the 4-slot barrel j4 core: slot identity,
//   cross-slot kill, per-slot watchdogs and one-deep inter-slot mailboxes.
//   Reads are answered in the cycle after the access; writes are captured
//   and applied one cycle later.
//   clk    : clock
//   resetq : async active-low reset
//   bus    : j4 IO bus (slave side), see j4_slot_io_if
//   BASE     : IO window base, decode on mem_addr[15:4]
//   WDOG_DIV : clk cycles per watchdog tick (>= 2)
module j4_slot_io
  import j4_slot_io_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'h1000,
  parameter int          WDOG_DIV = 1024
) (
  input  logic         clk,
  input  logic         resetq,
  j4_slot_io_if.slave  bus
);

  localparam int             PW         = $clog2(WDOG_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(WDOG_DIV - 1);

  logic          hit;
  logic [3:0]    off;
  logic          rd_any;
  logic          rd_hit;
  wr_acc_t       cap_q;

  logic [PW-1:0] presc;
  logic          tick;

  logic [15:0]   wd_cnt [N_SLOT];
  logic [3:0]    expire_vec;
  logic [3:0]    kill_vec;
  logic          kick_wr;
  logic          mbox_wr;
  logic [1:0]    mbox_tgt;

  logic [3:0]    full, full_d;
  logic [3:0]    ovf, ovf_d;
  logic [15:0]   mbox   [N_SLOT];
  logic [15:0]   mbox_d [N_SLOT];

  logic [15:0]   rd_data;
  logic [15:0]   io_din_q;
  logic [3:0]    kill_q;

  assign hit    = bus.mem_addr[15:4] == BASE[15:4];
  assign off    = bus.mem_addr[3:0];
  // Read together with write is treated as a write only
  assign rd_any = bus.io_rd && !bus.io_wr;
  assign rd_hit = rd_any && hit;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cap_q <= '0;
    end else begin
      cap_q.wr   <= bus.io_wr && hit;
      cap_q.off  <= off;
      cap_q.data <= bus.dout;
      cap_q.slot <= bus.io_slot;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PRESC_LAST);

  assign kill_vec = (cap_q.wr && cap_q.off == OFF_KILL) ? cap_q.data[3:0] : 4'h0;
  assign kick_wr  = cap_q.wr && cap_q.off == OFF_WDKICK;
  assign mbox_wr  = cap_q.wr && is_mbox_off(cap_q.off);
  assign mbox_tgt = cap_q.off[1:0];

  for (genvar g = 0; g < N_SLOT; g++) begin : g_wdog
    j4_wdog u_wdog (
      .clk      (clk),
      .resetq   (resetq),
      .tick     (tick),
      .kick     (kick_wr && cap_q.slot == 2'(g)),
      .kick_val (cap_q.data),
      .clear    (kill_vec[g]),
      .count    (wd_cnt[g]),
      .expire   (expire_vec[g])
    );
  end

  // Mailbox/flag next state. Order matters: read side effects first, then
  // the captured write (so a write in the same cycle as the owner's read
  // still lands), then kill which empties the slot unconditionally.
  always_comb begin
    full_d = full;
    ovf_d  = ovf;
    mbox_d = mbox;
    if (rd_hit && off == OFF_MBSTAT) begin
      ovf_d[bus.io_slot] = 1'b0;
    end
    if (rd_hit && off == OFF_MBOX) begin
      full_d[bus.io_slot] = 1'b0;
      mbox_d[bus.io_slot] = '0;
    end
    if (mbox_wr) begin
      if (full_d[mbox_tgt]) begin
        ovf_d[mbox_tgt] = 1'b1;
      end else begin
        full_d[mbox_tgt] = 1'b1;
        mbox_d[mbox_tgt] = cap_q.data;
      end
    end
    for (int n = 0; n < N_SLOT; n++) begin
      if (kill_vec[n]) begin
        full_d[n] = 1'b0;
        ovf_d[n]  = 1'b0;
        mbox_d[n] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      full <= '0;
      ovf  <= '0;
      for (int n = 0; n < N_SLOT; n++) mbox[n] <= '0;
    end else begin
      full <= full_d;
      ovf  <= ovf_d;
      for (int n = 0; n < N_SLOT; n++) mbox[n] <= mbox_d[n];
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (off)
        OFF_SLOTID: rd_data = {14'b0, bus.io_slot};
        OFF_WDCNT:  rd_data = wd_cnt[bus.io_slot];
        OFF_MBSTAT: rd_data = {8'b0, ovf, full};
        OFF_MBOX:   rd_data = full[bus.io_slot] ? mbox[bus.io_slot] : 16'h0000;
        default:    rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      io_din_q <= '0;
      kill_q   <= '0;
    end else begin
      if (rd_any) io_din_q <= rd_data;
      // Register-write kill and watchdog expiry merge into one pulse
      kill_q <= kill_vec | expire_vec;
    end
  end

  assign bus.io_din       = io_din_q;
  assign bus.kill_slot_rq = kill_q;

endmodule
